// File: rtl/rename_commit_queue_pkg.sv
// Wrap-bit pointer helpers (full/empty/count) shared by the circular queues.
// Pointers are passed zero-extended to wptr_t along with their index width.
package rename_commit_queue_pkg;

  localparam int PTR_MAX = 16;
  typedef logic [PTR_MAX:0] wptr_t;

  function automatic logic ptr_empty(input wptr_t h, input wptr_t t);
    return h == t;
  endfunction

  // Full when the pointers differ only in the wrap bit.
  function automatic logic ptr_full(input wptr_t h, input wptr_t t, input int pw);
    wptr_t msb;
    msb = wptr_t'(1) << pw;
    return (h ^ t) == msb;
  endfunction

  function automatic wptr_t ptr_count(input wptr_t h, input wptr_t t, input int pw);
    wptr_t mask;
    mask = (wptr_t'(1) << (pw + 1)) - wptr_t'(1);
    return (t - h) & mask;
  endfunction

endpackage

// File: rtl/rename_commit_queue_ring_ptr.sv
// Wrap-bit ring pointer with increment and load; load has priority over increment.
// Single-cycle update, no backpressure of its own.
module ring_ptr #(
  parameter int width = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic [width-1:0] ptr
);

  always_ff @(posedge CLK) begin
    if (RST)       ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + width'(1);
  end

endmodule

// File: rtl/rename_commit_queue.sv
// In-order commit queue returning physical names to the rename free list; commit one cycle
// after head is done, FREE_* registered; enqueue refused when full or during rollback.
module rename_commit_queue
  import rename_commit_queue_pkg::*;
#(
  parameter int name_width = 6,
  parameter int depth      = 8,
  parameter int ptr_width  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENQ_E,
  input  logic [name_width-1:0] ENQ_NAME,
  output logic                  ENQ_READY,
  output logic [ptr_width-1:0]  ENQ_TAG,
  input  logic                  DONE_E,
  input  logic [ptr_width-1:0]  DONE_TAG,
  output logic                  FREE_E,
  output logic [name_width-1:0] FREE_NAME,
  output logic [ptr_width:0]    SNAP_PTR,
  input  logic                  ROLL_E,
  input  logic [ptr_width:0]    ROLL_PTR,
  output logic [ptr_width:0]    COUNT
);

  localparam int PW1 = ptr_width + 1;

  logic [ptr_width:0]    head;
  logic [ptr_width:0]    tail;
  logic [ptr_width-1:0]  head_idx;
  logic [ptr_width-1:0]  tail_idx;
  logic [depth-1:0]      done_q;
  logic [name_width-1:0] names [depth];

  logic                  full;
  logic                  empty;
  logic                  enq_fire;
  logic                  commit;
  logic [ptr_width-1:0]  done_off;
  logic [ptr_width:0]    live;
  logic                  done_ok;

  assign head_idx = head[ptr_width-1:0];
  assign tail_idx = tail[ptr_width-1:0];

  assign full  = ptr_full(wptr_t'(head), wptr_t'(tail), ptr_width);
  assign empty = ptr_empty(wptr_t'(head), wptr_t'(tail));
  assign COUNT = PW1'(ptr_count(wptr_t'(head), wptr_t'(tail), ptr_width));

  assign ENQ_READY = !full && !ROLL_E;
  assign ENQ_TAG   = tail_idx;
  assign SNAP_PTR  = tail;
  assign enq_fire  = ENQ_E && ENQ_READY;

  // Rolling back to head empties the queue, so the head entry is squashed, not committed.
  assign commit = !empty && done_q[head_idx] && !(ROLL_E && (ROLL_PTR == head));

  // A done tag is live if its distance from head is inside the post-rollback occupancy.
  assign done_off = DONE_TAG - head_idx;
  assign live     = ROLL_E ? (ROLL_PTR - head) : COUNT;
  assign done_ok  = DONE_E && ({1'b0, done_off} < live);

  ring_ptr #(.width(PW1)) u_head (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (commit),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head)
  );

  ring_ptr #(.width(PW1)) u_tail (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (enq_fire),
    .load     (ROLL_E),
    .load_val (ROLL_PTR),
    .ptr      (tail)
  );

  always_ff @(posedge CLK) begin
    if (enq_fire) names[tail_idx] <= ENQ_NAME;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q <= '0;
    end else begin
      if (enq_fire) done_q[tail_idx] <= 1'b0;
      if (done_ok)  done_q[DONE_TAG] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      FREE_E    <= 1'b0;
      FREE_NAME <= '0;
    end else begin
      FREE_E <= commit;
      if (commit) FREE_NAME <= names[head_idx];
    end
  end

endmodule

// File: tb/tb_rename_commit_queue.sv
// Directed bench for rename_commit_queue (depth 4) against an integer-pointer model.
module tb_rename_commit_queue;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENQ_E = 1'b0;
  logic [5:0] ENQ_NAME = '0;
  logic       ENQ_READY;
  logic [1:0] ENQ_TAG;
  logic       DONE_E = 1'b0;
  logic [1:0] DONE_TAG = '0;
  logic       FREE_E;
  logic [5:0] FREE_NAME;
  logic [2:0] SNAP_PTR;
  logic       ROLL_E = 1'b0;
  logic [2:0] ROLL_PTR = '0;
  logic [2:0] COUNT;

  rename_commit_queue #(.name_width(6), .depth(4), .ptr_width(2)) dut (
    .CLK(CLK), .RST(RST),
    .ENQ_E(ENQ_E), .ENQ_NAME(ENQ_NAME), .ENQ_READY(ENQ_READY), .ENQ_TAG(ENQ_TAG),
    .DONE_E(DONE_E), .DONE_TAG(DONE_TAG),
    .FREE_E(FREE_E), .FREE_NAME(FREE_NAME), .SNAP_PTR(SNAP_PTR),
    .ROLL_E(ROLL_E), .ROLL_PTR(ROLL_PTR), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: absolute (never wrapping) head/tail, names and done flags per slot.
  bit m_valid = 0;
  int m_head = 0;
  int m_tail = 0;
  int m_name [4];
  bit m_done [4];
  bit e_free_e = 0;
  int e_free_name = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("enq_ready", int'(ENQ_READY), int'((m_tail - m_head) < 4 && !ROLL_E));
      chk("enq_tag",   int'(ENQ_TAG),   m_tail % 4);
      chk("count",     int'(COUNT),     m_tail - m_head);
      chk("snap_ptr",  int'(SNAP_PTR),  m_tail % 8);
      chk("free_e",    int'(FREE_E),    int'(e_free_e));
      chk("free_name", int'(FREE_NAME), e_free_name);
    end
  end

  task automatic cycle(input bit rst, input bit enq, input int nm, input bit dn,
                       input int dt, input bit roll, input int rp);
    int  cnt, off, ra, lim, a;
    bit  rdy, cm, dset;
    RST      = rst;
    ENQ_E    = enq;
    ENQ_NAME = 6'(nm);
    DONE_E   = dn;
    DONE_TAG = 2'(dt);
    ROLL_E   = roll;
    ROLL_PTR = 3'(rp);
    @(posedge CLK);
    if (rst) begin
      m_head = 0; m_tail = 0;
      for (int i = 0; i < 4; i++) m_done[i] = 0;
      e_free_e = 0; e_free_name = 0;
    end else begin
      cnt = m_tail - m_head;
      rdy = (cnt < 4) && !roll;
      ra  = m_tail;
      if (roll) begin
        off = (rp - (m_head % 8) + 8) % 8;
        chk("roll_ptr_legal", int'(off <= cnt), 1);
        ra = m_head + off;
      end
      cm   = (cnt > 0) && m_done[m_head % 4] && !(roll && ra == m_head);
      lim  = roll ? ra : m_tail;
      dset = 0;
      if (dn) begin
        a = m_head + ((dt - (m_head % 4) + 4) % 4);
        dset = (a < lim);
      end
      e_free_e = cm;
      if (cm) e_free_name = m_name[m_head % 4];
      if (enq && rdy) begin
        m_name[m_tail % 4] = nm;
        m_done[m_tail % 4] = 0;
        m_tail++;
      end
      if (roll) m_tail = ra;
      if (dset) m_done[dt] = 1;
      if (cm) m_head++;
    end
    m_valid = 1;
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  int snap;

  initial begin
    cycle(1, 1, 5, 1, 0, 0, 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_ready", int'(ENQ_READY), 1);
    chk("rst_tag", int'(ENQ_TAG), 0);
    chk("rst_free_e", int'(FREE_E), 0);

    // Fill, then an ignored fifth enqueue
    for (int i = 0; i < 4; i++) begin
      chk("fill_tag", int'(ENQ_TAG), i);
      cycle(0, 1, 10 + i, 0, 0, 0, 0);
    end
    chk("full_count", int'(COUNT), 4);
    chk("full_ready", int'(ENQ_READY), 0);
    cycle(0, 1, 14, 0, 0, 0, 0);
    chk("ovf_count", int'(COUNT), 4);

    // Out-of-order done, in-order free; enqueue refused in commit cycle, then wraps
    cycle(0, 0, 0, 1, 1, 0, 0);
    chk("ooo_no_free", int'(FREE_E), 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("done0_no_free_yet", int'(FREE_E), 0);
    cycle(0, 1, 20, 0, 0, 0, 0);
    chk("free_first", int'(FREE_E), 1);
    chk("free_name_10", int'(FREE_NAME), 10);
    chk("refused_count", int'(COUNT), 3);
    chk("wrap_tag", int'(ENQ_TAG), 0);
    cycle(0, 1, 20, 0, 0, 0, 0);
    chk("free_name_11", int'(FREE_NAME), 11);
    chk("accept_tag", int'(ENQ_TAG), 1);
    idle();
    chk("free_idle", int'(FREE_E), 0);

    // Rollback to a snapshot; same-cycle done and enqueue on squashed slots are dropped
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 30, 0, 0, 0, 0);
    snap = int'(SNAP_PTR);
    chk("snap_lit", snap, 1);
    cycle(0, 1, 31, 0, 0, 0, 0);
    cycle(0, 1, 32, 0, 0, 0, 0);
    cycle(0, 1, 33, 1, 2, 1, snap);
    chk("roll_count", int'(COUNT), 1);
    chk("roll_tag", int'(ENQ_TAG), 1);
    cycle(0, 0, 0, 1, 2, 0, 0);
    chk("stale_done_count", int'(COUNT), 1);
    cycle(0, 1, 33, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("roll_head_no_free", int'(FREE_E), 0);
    chk("roll_head_count", int'(COUNT), 0);
    idle();
    chk("roll_head_free_name", int'(FREE_NAME), 0);

    // Rollback not to head lets the pending commit proceed
    cycle(0, 1, 40, 0, 0, 0, 0);
    cycle(0, 1, 41, 0, 0, 0, 0);
    cycle(0, 1, 42, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    chk("roll_commit_free", int'(FREE_E), 1);
    chk("roll_commit_name", int'(FREE_NAME), 40);
    chk("roll_commit_count", int'(COUNT), 0);

    // Reset with a commit pending
    cycle(0, 1, 50, 0, 0, 0, 0);
    cycle(0, 1, 51, 0, 0, 0, 0);
    cycle(0, 1, 52, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    cycle(1, 1, 53, 1, 2, 0, 0);
    chk("rst_mid_free", int'(FREE_E), 0);
    chk("rst_mid_count", int'(COUNT), 0);
    chk("rst_mid_ready", int'(ENQ_READY), 1);
    idle();
    chk("rst_mid_free2", int'(FREE_E), 0);

    // Streaming: enqueue every cycle, done trailing by two slots
    for (int i = 0; i < 16; i++) cycle(0, 1, i + 1, i >= 2, (i + 2) % 4, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, k, 0, 0);
    for (int k = 0; k < 4; k++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
